// File: rtl/bram_load_responder.sv
// Load-request responder: queues IFM/weight word reads, issues them one per cycle to a
// fixed-latency memory port and steers the returned words into the IFM or weight BRAM.
module bram_load_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT = 2,
  parameter logic [ADDR_W-1:0] WGT_OFFSET = ADDR_W'(32'h0010_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_ifm,
  input  logic [ADDR_W-1:0] addr_ifm,
  input  logic              req_wgt,
  input  logic [ADDR_W-1:0] addr_wgt,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              ifm_we,
  output logic [ADDR_W-1:0] ifm_waddr,
  output logic [DATA_W-1:0] ifm_wdata,
  output logic              wgt_we,
  output logic [ADDR_W-1:0] wgt_waddr,
  output logic [DATA_W-1:0] wgt_wdata,
  output logic              addr_valid,
  output logic              busy,
  output logic              ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ADDR_W-1:0] ifm_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wgt_q [FIFO_DEPTH];
  logic [PTR_W:0]    ifm_wr, ifm_rd, wgt_wr, wgt_rd;
  logic              ifm_empty, ifm_full, wgt_empty, wgt_full;
  logic [ADDR_W-1:0] ifm_head, wgt_head;
  logic              grant_ifm, grant_wgt, push_ifm, push_wgt;
  logic              prio_wgt;

  logic [MEM_LAT-1:0] tag_v;
  logic [MEM_LAT-1:0] tag_w;
  logic [ADDR_W-1:0]  tag_a [MEM_LAT];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign ifm_empty = (ifm_wr == ifm_rd);
  assign wgt_empty = (wgt_wr == wgt_rd);
  assign ifm_full  = (ifm_wr[PTR_W] != ifm_rd[PTR_W]) && (ifm_wr[PTR_W-1:0] == ifm_rd[PTR_W-1:0]);
  assign wgt_full  = (wgt_wr[PTR_W] != wgt_rd[PTR_W]) && (wgt_wr[PTR_W-1:0] == wgt_rd[PTR_W-1:0]);
  assign ifm_head  = ifm_q[ifm_rd[PTR_W-1:0]];
  assign wgt_head  = wgt_q[wgt_rd[PTR_W-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full queue is still taken
  assign push_ifm = req_ifm && (!ifm_full || grant_ifm);
  assign push_wgt = req_wgt && (!wgt_full || grant_wgt);

  always_comb begin
    grant_ifm   = !ifm_empty && (wgt_empty || !prio_wgt);
    grant_wgt   = !wgt_empty && !grant_ifm;
    mem_rd_en   = grant_ifm || grant_wgt;
    mem_rd_addr = '0;
    if (grant_ifm)
      mem_rd_addr = base_addr + ifm_head;
    else if (grant_wgt)
      mem_rd_addr = base_addr + WGT_OFFSET + wgt_head;
  end

  always_ff @(posedge clk) begin
    if (push_ifm) ifm_q[ifm_wr[PTR_W-1:0]] <= addr_ifm;
    if (push_wgt) wgt_q[wgt_wr[PTR_W-1:0]] <= addr_wgt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifm_wr   <= '0;
      ifm_rd   <= '0;
      wgt_wr   <= '0;
      wgt_rd   <= '0;
      prio_wgt <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push_ifm)  ifm_wr <= ifm_wr + 1'b1;
      if (push_wgt)  wgt_wr <= wgt_wr + 1'b1;
      if (grant_ifm) ifm_rd <= ifm_rd + 1'b1;
      if (grant_wgt) wgt_rd <= wgt_rd + 1'b1;
      if (mem_rd_en) prio_wgt <= grant_ifm;
      if ((req_ifm && !push_ifm) || (req_wgt && !push_wgt)) ovf <= 1'b1;
    end
  end

  // Stage MEM_LAT-1 lines up with mem_rd_data for the read issued MEM_LAT cycles earlier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      tag_w <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_a[i] <= '0;
    end else begin
      tag_v[0] <= mem_rd_en;
      tag_w[0] <= grant_wgt;
      tag_a[0] <= grant_wgt ? wgt_head : ifm_head;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_w[i] <= tag_w[i-1];
        tag_a[i] <= tag_a[i-1];
      end
    end
  end

  always_comb begin
    ifm_we     = tag_v[MEM_LAT-1] && !tag_w[MEM_LAT-1];
    wgt_we     = tag_v[MEM_LAT-1] && tag_w[MEM_LAT-1];
    ifm_waddr  = ifm_we ? tag_a[MEM_LAT-1] : '0;
    ifm_wdata  = ifm_we ? mem_rd_data : '0;
    wgt_waddr  = wgt_we ? tag_a[MEM_LAT-1] : '0;
    wgt_wdata  = wgt_we ? mem_rd_data : '0;
    addr_valid = ifm_we || wgt_we;
    busy       = !ifm_empty || !wgt_empty || (|tag_v);
  end

endmodule

// File: tb/tb_bram_load_responder.sv
// Cycle-stepped bench: queue-based reference model of the responder plus a latency-accurate memory.
module tb_bram_load_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH = 4;
  localparam int LAT = 2;
  localparam logic [31:0] OFF = 32'h0010_0000;
  localparam int RING = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_ifm = 1'b0, req_wgt = 1'b0;
  logic [31:0] addr_ifm = '0, addr_wgt = '0, base_addr = '0;
  logic mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data = '0;
  logic ifm_we, wgt_we, addr_valid, busy, ovf;
  logic [31:0] ifm_waddr, ifm_wdata, wgt_waddr, wgt_wdata;

  bram_load_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .MEM_LAT(LAT), .WGT_OFFSET(OFF)
  ) dut (
    .clk(clk), .rst(rst),
    .req_ifm(req_ifm), .addr_ifm(addr_ifm), .req_wgt(req_wgt), .addr_wgt(addr_wgt),
    .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .ifm_we(ifm_we), .ifm_waddr(ifm_waddr), .ifm_wdata(ifm_wdata),
    .wgt_we(wgt_we), .wgt_waddr(wgt_waddr), .wgt_wdata(wgt_wdata),
    .addr_valid(addr_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] qi[$];
  logic [31:0] qw[$];
  logic        prio_w = 1'b0;
  logic        m_ovf = 1'b0;
  int          inflight = 0;
  logic        exp_v [RING];
  logic        exp_w [RING];
  logic [31:0] exp_a [RING];
  logic [31:0] exp_d [RING];
  logic        mem_v [RING];
  logic [31:0] mem_a [RING];

  function automatic logic [31:0] hashw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic clearModel();
    qi.delete();
    qw.delete();
    prio_w = 1'b0;
    m_ovf = 1'b0;
    inflight = 0;
    for (int i = 0; i < RING; i++) exp_v[i] = 1'b0;
  endtask

  // One reset cycle; the memory keeps returning data for reads already in flight
  task automatic applyReset();
    int slot;
    @(negedge clk);
    rst = 1'b1;
    req_ifm = 1'b0;
    req_wgt = 1'b0;
    slot = cyc % RING;
    mem_rd_data = mem_v[slot] ? hashw(mem_a[slot]) : $urandom();
    mem_v[slot] = 1'b0;
    #1;
    checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
    checkOutput("rst_rd_addr", mem_rd_addr, 32'd0);
    checkOutput("rst_ifm_we", 32'(ifm_we), 32'd0);
    checkOutput("rst_wgt_we", 32'(wgt_we), 32'd0);
    checkOutput("rst_addr_valid", 32'(addr_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    clearModel();
    cyc++;
  endtask

  task automatic applyStimulus(input logic ri, input logic [31:0] ai,
                               input logic rw, input logic [31:0] aw, input logic [31:0] b);
    int slot, s2;
    logic gi, gw, ev, ew;
    logic [31:0] ead;
    @(negedge clk);
    rst = 1'b0;
    req_ifm = ri;
    addr_ifm = ai;
    req_wgt = rw;
    addr_wgt = aw;
    base_addr = b;
    slot = cyc % RING;
    s2 = (cyc + LAT) % RING;
    mem_rd_data = mem_v[slot] ? hashw(mem_a[slot]) : $urandom();
    mem_v[slot] = 1'b0;
    #1;
    gi = (qi.size() > 0) && ((qw.size() == 0) || !prio_w);
    gw = !gi && (qw.size() > 0);
    ead = gi ? b + qi[0] : (gw ? b + OFF + qw[0] : 32'd0);
    ev = exp_v[slot];
    ew = exp_w[slot];
    checkOutput("rd_en", 32'(mem_rd_en), 32'(gi || gw));
    checkOutput("rd_addr", mem_rd_addr, ead);
    checkOutput("ifm_we", 32'(ifm_we), 32'(ev && !ew));
    checkOutput("ifm_waddr", ifm_waddr, (ev && !ew) ? exp_a[slot] : 32'd0);
    checkOutput("ifm_wdata", ifm_wdata, (ev && !ew) ? exp_d[slot] : 32'd0);
    checkOutput("wgt_we", 32'(wgt_we), 32'(ev && ew));
    checkOutput("wgt_waddr", wgt_waddr, (ev && ew) ? exp_a[slot] : 32'd0);
    checkOutput("wgt_wdata", wgt_wdata, (ev && ew) ? exp_d[slot] : 32'd0);
    checkOutput("addr_valid", 32'(addr_valid), 32'(ev));
    checkOutput("busy", 32'(busy), 32'((qi.size() > 0) || (qw.size() > 0) || (inflight > 0)));
    checkOutput("ovf", 32'(ovf), 32'(m_ovf));
    if (ev) inflight--;
    exp_v[slot] = 1'b0;
    if (mem_rd_en) begin
      mem_v[s2] = 1'b1;
      mem_a[s2] = mem_rd_addr;
    end
    if (gi || gw) begin
      exp_v[s2] = 1'b1;
      exp_w[s2] = gw;
      exp_a[s2] = gi ? qi[0] : qw[0];
      exp_d[s2] = hashw(ead);
      inflight++;
      prio_w = gi;
      if (gi) void'(qi.pop_front());
      else void'(qw.pop_front());
    end
    if (ri) begin
      if (qi.size() < DEPTH) qi.push_back(ai);
      else m_ovf = 1'b1;
    end
    if (rw) begin
      if (qw.size() < DEPTH) qw.push_back(aw);
      else m_ovf = 1'b1;
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] b;
    for (int i = 0; i < RING; i++) begin
      mem_v[i] = 1'b0;
      exp_v[i] = 1'b0;
    end
    applyReset();

    // Single IFM request, then drain
    applyStimulus(1'b1, 32'd5, 1'b0, 32'd0, 32'h100);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h100);

    // Three cycles of both streams, interleaved issue
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(i), 1'b1, 32'(10 + i), 32'h200);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h200);

    // Continuous IFM stream
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'(i), 1'b0, 32'd0, 32'h300);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h300);

    // Both streams continuous: queues fill, full-with-pop accepted, then drops set ovf
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 32'(100 + i), 1'b1, 32'(200 + i), 32'h400);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h400);

    // Reset with reads in flight and requests queued, then check IFM gets first grant
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(50 + i), 1'b1, 32'(60 + i), 32'h500);
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h500);
    applyStimulus(1'b1, 32'd7, 1'b1, 32'd8, 32'h600);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 32'h600);

    // Randomized traffic with occasional resets and wrapping base addresses
    b = $urandom();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) b = $urandom();
      if ($urandom_range(0, 99) == 0) applyReset();
      else applyStimulus(1'($urandom_range(0, 2) != 0), $urandom(),
                         1'($urandom_range(0, 2) != 0), $urandom(), b);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
